// File: rtl/sd_pkg.sv
// Shared constants and types for the SD sector-read arbiter and its round-robin picker.
package sd_pkg;

   localparam int SD_SECTOR_W         = 32;
   localparam int SD_BYTES_PER_SECTOR = 512;

   localparam logic REQ_LOADER = 1'b0;
   localparam logic REQ_DEBUG  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_XFER,
      ST_RESP
   } arb_state_t;

endpackage

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not served last.
module sd_rr_arb2
   import sd_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   output logic       o_grant,
   output logic       o_grant_valid
);

   always_comb begin
      o_grant_valid = |i_valid;
      if (&i_valid) begin
         o_grant = ~i_last_grant;
      end else begin
         o_grant = i_valid[REQ_DEBUG];
      end
   end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD sector-read engine between the ROM loader and the UART debug dumper,
// steering the byte stream to the granted side and reporting completion or error.
module sd_sector_arbiter
   import sd_pkg::*;
#(
   parameter int SECTOR_W         = SD_SECTOR_W,
   parameter int TIMEOUT_CYC      = 27_000_000,
   parameter int BYTES_PER_SECTOR = SD_BYTES_PER_SECTOR
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_req0_valid,
   input  logic [SECTOR_W-1:0] i_req0_sector,
   output logic                o_req0_ready,
   output logic                o_rsp0_valid,
   output logic                o_rsp0_err,
   output logic                o_dat0_valid,
   input  logic                i_req1_valid,
   input  logic [SECTOR_W-1:0] i_req1_sector,
   output logic                o_req1_ready,
   output logic                o_rsp1_valid,
   output logic                o_rsp1_err,
   output logic                o_dat1_valid,
   output logic [7:0]          o_dat_byte,
   output logic [8:0]          o_dat_idx,
   output logic                o_sd_start,
   output logic [SECTOR_W-1:0] o_sd_sector,
   input  logic                i_sd_busy,
   input  logic                i_sd_done,
   input  logic                i_sd_byte_valid,
   input  logic [7:0]          i_sd_byte
);

   localparam int CNT_W = $clog2(BYTES_PER_SECTOR + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_SECTOR);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   logic                r_last_grant;
   logic                r_grant;
   logic [SECTOR_W-1:0] r_sd_sector;
   logic [1:0]          r_req_ready, r_rsp_valid, r_rsp_err, r_dat_valid;
   logic [1:0]          w_req_ready_next, w_rsp_valid_next, w_rsp_err_next, w_dat_valid_next;
   logic                r_sd_start, w_sd_start_next;
   logic [7:0]          r_dat_byte;
   logic [8:0]          r_dat_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_eff;
   logic                r_ovf;
   logic                w_ovf_eff;
   logic [TMR_W-1:0]    r_timer;
   logic                w_active, w_byte_acc, w_byte_ovf, w_timeout, w_finish, w_err;
   logic                w_gnt, w_gnt_valid;

   sd_rr_arb2 u_rr (
      .i_valid       ({i_req1_valid, i_req0_valid}),
      .i_last_grant  (r_last_grant),
      .o_grant       (w_gnt),
      .o_grant_valid (w_gnt_valid)
   );

   // Bytes are accepted while waiting for busy as well, so a byte racing busy is not lost.
   assign w_active   = (r_state == ST_WAIT_BUSY) || (r_state == ST_XFER);
   assign w_byte_acc = w_active && i_sd_byte_valid && (r_cnt != CNT_FULL);
   assign w_byte_ovf = w_active && i_sd_byte_valid && (r_cnt == CNT_FULL);
   assign w_cnt_eff  = r_cnt + CNT_W'(w_byte_acc);
   assign w_ovf_eff  = r_ovf | w_byte_ovf;
   assign w_timeout  = w_active && (r_timer == TMR_LAST);
   assign w_finish   = w_active && (w_timeout || i_sd_done);
   assign w_err      = w_timeout || w_ovf_eff || (w_cnt_eff != CNT_FULL);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:      if (w_gnt_valid) w_state_next = ST_ISSUE;
         ST_ISSUE:     w_state_next = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (w_finish) begin
               w_state_next = ST_RESP;
            end else if (i_sd_busy) begin
               w_state_next = ST_XFER;
            end
         end
         ST_XFER:      if (w_finish) w_state_next = ST_RESP;
         ST_RESP:      w_state_next = ST_IDLE;
         default:      w_state_next = ST_IDLE;
      endcase
   end

   // Every output is registered, so the response lands one cycle after sd_done.
   always_comb begin
      w_req_ready_next = 2'b00;
      w_rsp_valid_next = 2'b00;
      w_rsp_err_next   = 2'b00;
      w_dat_valid_next = 2'b00;
      w_sd_start_next  = 1'b0;
      case (r_state)
         ST_IDLE:  if (w_gnt_valid) w_req_ready_next[w_gnt] = 1'b1;
         ST_ISSUE: w_sd_start_next = 1'b1;
         ST_WAIT_BUSY, ST_XFER: begin
            if (w_byte_acc) w_dat_valid_next[r_grant] = 1'b1;
            if (w_finish) begin
               w_rsp_valid_next[r_grant] = 1'b1;
               w_rsp_err_next[r_grant]   = w_err;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_sd_sector  <= '0;
         r_req_ready  <= 2'b00;
         r_rsp_valid  <= 2'b00;
         r_rsp_err    <= 2'b00;
         r_dat_valid  <= 2'b00;
         r_sd_start   <= 1'b0;
         r_dat_byte   <= 8'd0;
         r_dat_idx    <= 9'd0;
         r_cnt        <= '0;
         r_ovf        <= 1'b0;
         r_timer      <= '0;
      end else begin
         r_req_ready <= w_req_ready_next;
         r_rsp_valid <= w_rsp_valid_next;
         r_rsp_err   <= w_rsp_err_next;
         r_dat_valid <= w_dat_valid_next;
         r_sd_start  <= w_sd_start_next;
         if ((r_state == ST_IDLE) && w_gnt_valid) begin
            r_grant     <= w_gnt;
            r_sd_sector <= w_gnt ? i_req1_sector : i_req0_sector;
         end
         if (r_state == ST_RESP) begin
            r_last_grant <= r_grant;
         end
         if (r_state == ST_ISSUE) begin
            r_timer <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
         end else if (w_active) begin
            r_timer <= r_timer + TMR_W'(1);
            r_cnt   <= w_cnt_eff;
            r_ovf   <= w_ovf_eff;
         end
         if (w_byte_acc) begin
            r_dat_byte <= i_sd_byte;
            r_dat_idx  <= 9'(r_cnt);
         end
      end
   end

   assign o_req0_ready = r_req_ready[REQ_LOADER];
   assign o_req1_ready = r_req_ready[REQ_DEBUG];
   assign o_rsp0_valid = r_rsp_valid[REQ_LOADER];
   assign o_rsp1_valid = r_rsp_valid[REQ_DEBUG];
   assign o_rsp0_err   = r_rsp_err[REQ_LOADER];
   assign o_rsp1_err   = r_rsp_err[REQ_DEBUG];
   assign o_dat0_valid = r_dat_valid[REQ_LOADER];
   assign o_dat1_valid = r_dat_valid[REQ_DEBUG];
   assign o_dat_byte   = r_dat_byte;
   assign o_dat_idx    = r_dat_idx;
   assign o_sd_start   = r_sd_start;
   assign o_sd_sector  = r_sd_sector;

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares the single SD sector-read engine (the SD controller behind the loader) between two requesters: requester 0 is the ROM/menu loader, requester 1 is the UART debug dumper.
- Accepts one sector request at a time and issues it to the SD engine.
- Routes the 512-byte data stream only to the granted requester, then returns completion or error status.
- Round-robin fairness, plus a watchdog so a hung card cannot lock out either requester.

Parameters:
- SECTOR_W, 32, width of the sector address.
- TIMEOUT_CYC, 27_000_000, cycles allowed from issue to sd_done before the transfer is aborted with an error (1 s at 27 MHz).
- BYTES_PER_SECTOR, 512, number of data bytes expected per sector.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a sector request pending.
- req0_sector  in  SECTOR_W  requester 0 sector address.
- req0_ready  out  1  requester 0 request accepted this cycle.
- rsp0_valid  out  1  one-cycle completion pulse to requester 0.
- rsp0_err  out  1  qualifies rsp0_valid: timeout or short/long transfer.
- dat0_valid  out  1  data byte strobe to requester 0.
- req1_valid, req1_sector, req1_ready, rsp1_valid, rsp1_err, dat1_valid  same as the requester-0 ports, for requester 1.
- dat_byte  out  8  shared data byte, valid only with datN_valid.
- dat_idx  out  9  byte index within the sector, 0..511.
- sd_start  out  1  one-cycle read-start pulse to the SD engine.
- sd_sector  out  SECTOR_W  sector address presented to the SD engine.
- sd_busy  in  1  SD engine is busy.
- sd_done  in  1  one-cycle pulse when the SD engine finishes.
- sd_byte_valid  in  1  SD engine data byte strobe.
- sd_byte  in  8  SD engine data byte.

Behaviour:
- Reset values (async reset, all outputs zero): reqN_ready, rspN_valid, rspN_err, datN_valid, sd_start, sd_sector, dat_byte, dat_idx all 0.
- Internal reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), byte counter=0, timer=0.
- Reset mid-transfer: everything returns to IDLE immediately; no response pulse is produced. Requesters must re-request.
- States: IDLE, ISSUE, WAIT_BUSY, XFER, RESP.
- IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the requester that is not last_grant.
  - On grant: reqN_ready=1 for exactly one cycle, latch reqN_sector into sd_sector, record grant, go to ISSUE.
  - A requester must hold reqN_valid and reqN_sector stable until reqN_ready is seen.
- ISSUE: sd_start=1 for one cycle, clear timer and byte counter, go to WAIT_BUSY.
- WAIT_BUSY: wait for sd_busy=1, then go to XFER. sd_done arriving without sd_busy is also accepted and goes straight to RESP.
- XFER:
  - Each sd_byte_valid forwards sd_byte/dat_idx to the granted requester only, registered with 1-cycle latency.
  - Counter increments per byte and saturates at 511 for dat_idx. Excess bytes are not forwarded but are flagged as overflow.
  - sd_done: go to RESP. err = (bytes received != BYTES_PER_SECTOR) or overflow.
  - A final sd_byte_valid coincident with sd_done is counted before the check.
- Timeout: timer runs from ISSUE through XFER. Reaching TIMEOUT_CYC-1 forces RESP with err=1; any later sd_done is ignored.
- RESP: rspN_valid=1 with rspN_err for one cycle to the granted requester, update last_grant, return to IDLE.
  - A new grant is possible on the cycle after RESP, so there is at least 1 idle cycle between transfers.
- Latency: grant to sd_start is 1 cycle. sd_done to rspN_valid is 1 cycle.
- Requests arriving during a transfer stay pending (ready held low). Deasserting req_valid before it is granted withdraws the request silently.

Decomposition:
- Shared package sd_pkg: SECTOR_W default, BYTES_PER_SECTOR, arbiter state enum, and requester ID constants REQ_LOADER=0, REQ_DEBUG=1.
- One natural sub-module: sd_rr_arb2, a 2-way round-robin picker (inputs: two valids and last_grant; outputs: grant index and grant-valid).
- The rest of the block is flat.

Test Plan:
- Single request: req0 for sector 0x10 alone → req0_ready pulse; sd_start one cycle later with sd_sector=0x10; model sends 512 bytes + sd_done → 512 dat0_valid with dat_idx 0..511, no dat1_valid, rsp0_valid=1, rsp0_err=0.
- Tie and fairness: req0 and req1 asserted together from reset → req0 granted first, req1 second. Both held continuously for 4 transfers → grant order 0,1,0,1.
- Short transfer: model sends 300 bytes then sd_done → rsp1_valid=1 with rsp1_err=1. The next request proceeds normally.
- Timeout: TIMEOUT_CYC=1000, model never asserts sd_done → rsp0_err=1 at cycle 1000 after issue. A late sd_done is ignored and produces no second response.
- Reset mid-XFER: assert reset after byte 100 → all outputs 0 immediately, no rsp pulse. After reset release, a pending req1 is granted before req0 (last_grant=1 on reset means req0 wins ties, so with only req1 pending it is granted directly).
- Edge timing: final byte coincident with sd_done → counted as byte 512, rsp_err=0.
